// File: rtl/hammer_pkg.sv
// Shared constants for the hammer-cell vector sequencer: state codes, MISR polynomial,
// operand packing of the 30-bit stimulus words, and the LFSR helpers.
package hammer_pkg;
  localparam int Y_W    = 31;
  localparam int STIM_W = 30;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DRIVE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Operands 0..5 packed MSB first: {op0[3:0],op1[4:0],op2[5:0],op3[3:0],op4[4:0],op5[5:0]}
  localparam int NUM_OPS = 6;
  localparam int OP_W   [NUM_OPS] = '{4, 5, 6, 4, 5, 6};
  localparam int OP_OFF [NUM_OPS] = '{26, 21, 15, 11, 6, 0};

  function automatic logic [63:0] seed_fix(input logic [63:0] s);
    return (s == 64'h0) ? 64'h1 : s;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction
endpackage

// File: rtl/hammer_misr.sv
// 32-bit multiple-input signature register folding a 31-bit response word per enable.
module hammer_misr
  import hammer_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           preset,
  input  logic [31:0]    preset_val,
  input  logic           en,
  input  logic [Y_W-1:0] data,
  output logic [31:0]    sig
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sig <= 32'h0;
    else if (preset) sig <= preset_val;
    else if (en)     sig <= {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ {1'b0, data};
  end
endmodule

// File: rtl/hammer_vec_sequencer.sv
// Applies LFSR stimulus to a combinational hammer cell, waits SETTLE cycles per vector,
// and compresses the responses into a MISR signature reported with a done pulse.
module hammer_vec_sequencer
  import hammer_pkg::*;
#(
  parameter int          NUM_VEC   = 256,
  parameter int          SETTLE    = 1,
  parameter logic [63:0] SEED      = 64'h1,
  parameter logic [31:0] MISR_INIT = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [STIM_W-1:0] stim_a,
  output logic [STIM_W-1:0] stim_b,
  output logic              stim_en,
  input  logic [Y_W-1:0]    y_in,
  output logic              busy,
  output logic              done,
  output logic [31:0]       signature,
  output logic [15:0]       vec_count
);
  localparam logic [63:0] SEED_EFF = seed_fix(SEED);
  localparam logic [3:0]  SETTLE_C = 4'(SETTLE);
  localparam logic [15:0] LAST_VEC = 16'(NUM_VEC - 1);

  logic [2:0]        state;
  logic [63:0]       lfsr;
  logic [3:0]        cnt;
  logic [STIM_W-1:0] a_nxt, b_nxt;
  logic              kill;

  // Unpack operands individually so the packing table is the single source of layout truth.
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    assign a_nxt[OP_OFF[i] +: OP_W[i]] = lfsr[OP_OFF[i] +: OP_W[i]];
    assign b_nxt[OP_OFF[i] +: OP_W[i]] = lfsr[STIM_W + OP_OFF[i] +: OP_W[i]];
  end

  assign kill    = abort && (state != ST_IDLE);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign stim_en = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lfsr      <= SEED_EFF;
      cnt       <= 4'd0;
      vec_count <= 16'd0;
      stim_a    <= '0;
      stim_b    <= '0;
    end else if (kill) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          lfsr      <= SEED_EFF;
          vec_count <= 16'd0;
          state     <= ST_DRIVE;
        end
        ST_DRIVE: begin
          stim_a <= a_nxt;
          stim_b <= b_nxt;
          cnt    <= SETTLE_C;
          state  <= (SETTLE_C == 4'd0) ? ST_CAPTURE : ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt <= 4'd1) state <= ST_CAPTURE;
          else             cnt   <= cnt - 4'd1;
        end
        ST_CAPTURE: begin
          lfsr      <= lfsr_step(lfsr);
          vec_count <= vec_count + 16'd1;
          state     <= (vec_count == LAST_VEC) ? ST_DONE : ST_DRIVE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // An abort in CAPTURE also suppresses the fold, leaving the partial signature untouched.
  hammer_misr u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .preset    ((state == ST_IDLE) && start),
    .preset_val(MISR_INIT),
    .en        ((state == ST_CAPTURE) && !kill),
    .data      (y_in),
    .sig       (signature)
  );
endmodule

// File: tb/tb_hammer_vec_sequencer.sv
// Directed bench: three sequencer configurations, a cycle-indexed run model for the
// NUM_VEC=4/SETTLE=2 instance, and literal expectations for the small/large runs.
module tb_hammer_vec_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_lfsr(input logic [63:0] l);
    logic fb;
    fb = l[63] ^ l[62] ^ l[60] ^ l[59];
    return (l << 1) | {63'h0, fb};
  endfunction

  function automatic logic [31:0] m_misr(input logic [31:0] m, input logic [30:0] y);
    logic [31:0] r;
    r = m << 1;
    if (m[31]) r = r ^ 32'h04C11DB7;
    return r ^ {1'b0, y};
  endfunction

  function automatic logic [30:0] y_of(input logic [29:0] a, input logic [29:0] b);
    return {1'b1, a} ^ {b, 1'b0};
  endfunction

  // Instance A: single vector, no settle
  logic ua_start, ua_abort, ua_en, ua_busy, ua_done;
  logic [29:0] ua_sa, ua_sb;
  logic [31:0] ua_sig;
  logic [15:0] ua_vc;
  hammer_vec_sequencer #(.NUM_VEC(1), .SETTLE(0), .SEED(64'h1), .MISR_INIT(32'hFFFFFFFF)) u_a (
    .clk(clk), .rst_n(rst_n), .start(ua_start), .abort(ua_abort), .stim_a(ua_sa), .stim_b(ua_sb),
    .stim_en(ua_en), .y_in(31'h0), .busy(ua_busy), .done(ua_done), .signature(ua_sig), .vec_count(ua_vc));

  // Instance B: modelled every cycle
  localparam int NB = 4, SB = 2, PB = SB + 2, KB = NB * PB;
  localparam logic [63:0] SEED_B = 64'hDEADBEEF12345678;
  logic ub_start, ub_abort, ub_en, ub_busy, ub_done;
  logic [29:0] ub_sa, ub_sb;
  logic [31:0] ub_sig;
  logic [15:0] ub_vc;
  logic [30:0] ub_y;
  assign ub_y = y_of(ub_sa, ub_sb);
  hammer_vec_sequencer #(.NUM_VEC(NB), .SETTLE(SB), .SEED(SEED_B), .MISR_INIT(32'hFFFFFFFF)) u_b (
    .clk(clk), .rst_n(rst_n), .start(ub_start), .abort(ub_abort), .stim_a(ub_sa), .stim_b(ub_sb),
    .stim_en(ub_en), .y_in(ub_y), .busy(ub_busy), .done(ub_done), .signature(ub_sig), .vec_count(ub_vc));

  // Instance C: long run, zero preset, zero seed (replaced by 1)
  logic uc_start, uc_abort, uc_en, uc_busy, uc_done;
  logic [29:0] uc_sa, uc_sb;
  logic [31:0] uc_sig;
  logic [15:0] uc_vc;
  hammer_vec_sequencer #(.NUM_VEC(256), .SETTLE(1), .SEED(64'h0), .MISR_INIT(32'h0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(uc_start), .abort(uc_abort), .stim_a(uc_sa), .stim_b(uc_sb),
    .stim_en(uc_en), .y_in(31'h0), .busy(uc_busy), .done(uc_done), .signature(uc_sig), .vec_count(uc_vc));

  // Run model for B: k = edges since the start edge; vector v occupies k in [v*PB, v*PB+PB).
  logic [29:0] va [NB];
  logic [29:0] vb [NB];
  logic [31:0] sexp [NB+1];
  initial begin : model
    logic [63:0] l;
    int m_k, m_vc;
    logic [31:0] m_sig;
    logic [29:0] m_sa, m_sb;
    l = SEED_B;
    sexp[0] = 32'hFFFFFFFF;
    for (int v = 0; v < NB; v++) begin
      va[v] = l[29:0];
      vb[v] = l[59:30];
      sexp[v+1] = m_misr(sexp[v], y_of(va[v], vb[v]));
      l = m_lfsr(l);
    end
    m_k = -1; m_vc = 0; m_sig = '0; m_sa = '0; m_sb = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_k = -1; m_vc = 0; m_sig = '0; m_sa = '0; m_sb = '0;
      end else if (m_k < 0) begin
        if (ub_start) begin m_k = 0; m_vc = 0; m_sig = sexp[0]; end
      end else if (ub_abort) begin
        m_k = -1;
      end else begin
        m_k++;
        if (m_k > KB) m_k = -1;
        else begin m_vc = m_k / PB; m_sig = sexp[m_vc]; end
      end
      if (m_k >= 0 && m_k < KB && (m_k % PB) >= 1) begin
        m_sa = va[m_k / PB];
        m_sb = vb[m_k / PB];
      end
      @(negedge clk);
      if (!rst_n) begin
        m_k = -1; m_vc = 0; m_sig = '0; m_sa = '0; m_sb = '0;
      end
      chk("b_busy", 64'(ub_busy), 64'(m_k >= 0));
      chk("b_done", 64'(ub_done), 64'(m_k == KB));
      chk("b_stim_en", 64'(ub_en), 64'(m_k >= 0 && m_k < KB));
      chk("b_vec_count", 64'(ub_vc), 64'(m_vc));
      chk("b_signature", 64'(ub_sig), 64'(m_sig));
      chk("b_stim_a", 64'(ub_sa), 64'(m_sa));
      chk("b_stim_b", 64'(ub_sb), 64'(m_sb));
    end
  end

  task automatic run_b(input bit poke, input bit abort_at_start, input int abort_k,
                       output int kdone, output int busy_cnt);
    ub_start = 1'b1; ub_abort = abort_at_start;
    @(negedge clk);
    ub_start = 1'b0; ub_abort = 1'b0;
    kdone = -1; busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      ub_start = poke && (k == 5 || k == KB);
      ub_abort = (k == abort_k);
      if (ub_done) begin kdone = k; break; end
      if (ub_busy) busy_cnt++;
      if (abort_k >= 0 && k == abort_k + 1) break;
    end
    @(negedge clk);
    ub_start = 1'b0; ub_abort = 1'b0;
  endtask

  task automatic run_a_check_sig(input string tag);
    ua_start = 1'b1;
    @(negedge clk); ua_start = 1'b0;
    chk({tag, "_k0_busy"}, 64'(ua_busy), 64'd1);
    chk({tag, "_k0_sig"}, 64'(ua_sig), 64'hFFFFFFFF);
    @(negedge clk);
    chk({tag, "_k1_stim_a"}, 64'(ua_sa), 64'h1);
    chk({tag, "_k1_stim_b"}, 64'(ua_sb), 64'h0);
    chk({tag, "_k1_done"}, 64'(ua_done), 64'd0);
    @(negedge clk);
    chk({tag, "_k2_done"}, 64'(ua_done), 64'd1);
    chk({tag, "_k2_sig"}, 64'(ua_sig), 64'hFB3EE249);
    chk({tag, "_k2_vc"}, 64'(ua_vc), 64'd1);
    chk({tag, "_k2_stim_en"}, 64'(ua_en), 64'd0);
    @(negedge clk);
    chk({tag, "_k3_busy"}, 64'(ua_busy), 64'd0);
    chk({tag, "_k3_done"}, 64'(ua_done), 64'd0);
  endtask

  initial begin
    int kd, bc, kc;
    logic [31:0] sig_ref;
    logic [29:0] c_first;
    rst_n = 1'b0;
    ua_start = 0; ua_abort = 0; ub_start = 0; ub_abort = 0; uc_start = 0; uc_abort = 0;

    // Pin the bench model with hand-computed values
    chk("model_lfsr_1", m_lfsr(64'h1), 64'h2);
    chk("model_lfsr_msb", m_lfsr(64'h8000000000000000), 64'h1);
    chk("model_lfsr_b60", m_lfsr(64'h1000000000000000), 64'h2000000000000001);
    chk("model_misr", 64'(m_misr(32'hFFFFFFFF, 31'h0)), 64'hFB3EE249);

    @(negedge clk);
    chk("rst_busy", 64'(ua_busy), 64'd0);
    chk("rst_done", 64'(ua_done), 64'd0);
    chk("rst_sig", 64'(ua_sig), 64'd0);
    chk("rst_vc", 64'(ua_vc), 64'd0);
    chk("rst_stim", 64'({ua_sa, ua_sb, ua_en}), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    run_a_check_sig("s1");

    run_b(1'b0, 1'b0, -1, kd, bc);
    chk("s2_done_edge", 64'(kd), 64'(KB));
    chk("s2_busy_cycles", 64'(bc), 64'd16);
    sig_ref = ub_sig;
    chk("s2_sig_model", 64'(sig_ref), 64'(sexp[NB]));

    run_b(1'b1, 1'b0, -1, kd, bc);
    chk("s5_done_edge", 64'(kd), 64'(KB));
    chk("s5_sig_same", 64'(ub_sig), 64'(sig_ref));
    chk("s5_idle_after_done", 64'(ub_busy), 64'd0);

    run_b(1'b0, 1'b0, 9, kd, bc);
    chk("s4_no_done", 64'(kd), 64'hFFFFFFFFFFFFFFFF);
    chk("s4_vc", 64'(ub_vc), 64'd2);
    chk("s4_idle", 64'(ub_busy), 64'd0);
    run_b(1'b0, 1'b1, -1, kd, bc);
    chk("s4_restart_done_edge", 64'(kd), 64'(KB));
    chk("s4_restart_sig", 64'(ub_sig), 64'(sig_ref));

    run_b(1'b0, 1'b0, 15, kd, bc);
    chk("abort_last_capture_no_done", 64'(kd), 64'hFFFFFFFFFFFFFFFF);
    chk("abort_last_capture_vc", 64'(ub_vc), 64'd3);

    uc_start = 1'b1;
    @(negedge clk); uc_start = 1'b0;
    kc = -1; c_first = '1;
    for (int k = 0; k < 900; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) c_first = uc_sa;
      if (uc_done) begin kc = k; break; end
    end
    chk("s3_done_edge", 64'(kc), 64'd768);
    chk("s3_sig", 64'(uc_sig), 64'd0);
    chk("s3_vc", 64'(uc_vc), 64'd256);
    chk("s3_zero_seed_stim", 64'(c_first), 64'd1);
    @(negedge clk);

    ua_start = 1'b1;
    @(negedge clk); ua_start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("s6_busy", 64'(ua_busy), 64'd0);
    chk("s6_done", 64'(ua_done), 64'd0);
    chk("s6_sig", 64'(ua_sig), 64'd0);
    chk("s6_vc", 64'(ua_vc), 64'd0);
    chk("s6_stim", 64'({ua_sa, ua_sb, ua_en}), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    run_a_check_sig("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
